// File: rtl/arb_pkg.sv
// Shared arbitration helpers: index width, round-robin pick function and pick result type.
// Intended for reuse by the round-robin and future fixed-priority arbiters.
package arb_pkg;

  localparam int unsigned ARB_MAX_REQ   = 32;
  localparam int unsigned ARB_MAX_IDX_W = 5;
  localparam int unsigned ARB_NUM_REQ   = 4;
  localparam int unsigned ARB_IDX_W     = $clog2(ARB_NUM_REQ);

  typedef logic [ARB_IDX_W-1:0] arb_idx_t;

  typedef struct packed {
    logic                     found;
    logic [ARB_MAX_IDX_W-1:0] idx;
  } arb_pick_t;

  function automatic int unsigned arb_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Scan ptr, ptr+1, ... modulo n (n must be a power of two, <= ARB_MAX_REQ).
  function automatic arb_pick_t rr_pick(input logic [ARB_MAX_REQ-1:0] valid,
                                        input int unsigned           ptr,
                                        input int unsigned           n);
    arb_pick_t   r;
    int unsigned j;
    r = '0;
    for (int unsigned k = 0; k < ARB_MAX_REQ; k++) begin
      j = (ptr + k) & (n - 1);
      if ((k < n) && !r.found && valid[j[ARB_MAX_IDX_W-1:0]]) begin
        r.found = 1'b1;
        r.idx   = j[ARB_MAX_IDX_W-1:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_mux_arbiter_mux.sv
// One-bit MUX_WIDTH:1 multiplexer cell. With a non-zero GATE_DELAY it is built as a
// log2(MUX_WIDTH)-deep tree of 2:1 stages; a zero-delay build uses a flat index.
module Mux #(
  parameter  int unsigned MUX_WIDTH  = 4,
  parameter  int unsigned GATE_DELAY = 50,
  localparam int unsigned SEL_W      = $clog2(MUX_WIDTH)
) (
  input  logic [MUX_WIDTH-1:0] i_data,
  input  logic [SEL_W-1:0]     i_sel,
  output logic                 o_y
);

  genvar gi, gj;

  generate
    if (GATE_DELAY > 0) begin : g_tree
      // Level gi halves the candidate set using select bit gi (LSB first).
      for (gi = 0; gi < SEL_W; gi++) begin : g_lvl
        localparam int unsigned N = MUX_WIDTH >> (gi + 1);
        logic [N-1:0] w_v;
        for (gj = 0; gj < N; gj++) begin : g_n
          if (gi == 0) begin : g_leaf
            assign w_v[gj] = i_sel[gi] ? i_data[2*gj+1] : i_data[2*gj];
          end else begin : g_inner
            assign w_v[gj] = i_sel[gi] ? g_lvl[gi-1].w_v[2*gj+1] : g_lvl[gi-1].w_v[2*gj];
          end
        end
      end
      assign o_y = g_lvl[SEL_W-1].w_v[0];
    end else begin : g_flat
      assign o_y = i_data[i_sel];
    end
  endgenerate

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter steering NUM_REQ valid/ready requesters onto one registered output.
// Optional grant counter port perf_grants is enabled by defining ARB_PERF_CNT_EN.
module rr_mux_arbiter
  import arb_pkg::*;
#(
  parameter  int unsigned NUM_REQ    = 4,
  parameter  int unsigned DATA_WIDTH = 32,
  parameter  int unsigned GATE_DELAY = 50,
  localparam int unsigned IDX_W      = arb_idx_w(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          out_valid,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [IDX_W-1:0]              out_src,
  input  logic                          out_ready
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]                   perf_grants
`endif
);

  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic [IDX_W-1:0]      r_out_src;
  logic [IDX_W-1:0]      r_ptr;

  logic                  w_can_load;
  logic                  w_grant;
  arb_pick_t             w_pick;
  logic [IDX_W-1:0]      w_win;
  logic [DATA_WIDTH-1:0] w_mux_out;
  logic [NUM_REQ-1:0]    w_col [DATA_WIDTH];
  logic                  w_unused_idx;

  always_comb begin
    w_can_load = !r_out_valid | out_ready;
    w_pick     = rr_pick(ARB_MAX_REQ'(req_valid), 32'(r_ptr), NUM_REQ);
    w_win      = w_pick.idx[IDX_W-1:0];
    w_grant    = w_can_load & w_pick.found & !reset;
    req_ready  = '0;
    if (w_grant) begin
      req_ready[w_win] = 1'b1;
    end
  end

  assign w_unused_idx = ^w_pick.idx;

  // Bit-sliced data path: cell gi sees bit gi of every requester's payload.
  genvar gi, gj;
  generate
    for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_bit
      for (gj = 0; gj < NUM_REQ; gj++) begin : g_req
        assign w_col[gi][gj] = req_data[gj*DATA_WIDTH + gi];
      end
      Mux #(
        .MUX_WIDTH  (NUM_REQ),
        .GATE_DELAY (GATE_DELAY)
      ) u_mux (
        .i_data (w_col[gi]),
        .i_sel  (w_win),
        .o_y    (w_mux_out[gi])
      );
    end
  endgenerate

`ifdef ARB_PERF_CNT_EN
  logic [31:0] r_perf_grants;
  assign perf_grants = r_perf_grants;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_src   <= '0;
      r_ptr       <= '0;
`ifdef ARB_PERF_CNT_EN
      r_perf_grants <= '0;
`endif
    end else if (w_grant) begin
      // Load has priority over a simultaneous drain, keeping out_valid high.
      r_out_valid <= 1'b1;
      r_out_data  <= w_mux_out;
      r_out_src   <= w_win;
      r_ptr       <= w_win + 1'b1;
`ifdef ARB_PERF_CNT_EN
      r_perf_grants <= r_perf_grants + 32'd1;
`endif
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_src   = r_out_src;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Scoreboard bench for rr_mux_arbiter: a reference round-robin model pushes expected
// payloads at grant time; they are popped and compared when the output register loads.
module tb_rr_mux_arbiter;

  localparam int NR = 4;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic [NR-1:0]   req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]   req_ready;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic [1:0]      out_src;
  logic            out_ready;
`ifdef ARB_PERF_CNT_EN
  logic [31:0]     perf_grants;
`endif

  always #5 clk = ~clk;

  rr_mux_arbiter #(
    .NUM_REQ    (NR),
    .DATA_WIDTH (DW),
    .GATE_DELAY (50)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready)
`ifdef ARB_PERF_CNT_EN
    ,
    .perf_grants (perf_grants)
`endif
  );

  typedef struct packed {
    logic [1:0]  src;
    logic [31:0] data;
  } exp_t;

  exp_t        sb_q[$];
  int          checks   = 0;
  int          failures = 0;
  int          txn      = 0;
  logic        m_valid  = 1'b0;
  logic [31:0] m_data   = '0;
  logic [1:0]  m_src    = '0;
  int          m_ptr    = 0;
  logic [31:0] m_perf   = '0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (txn %0d)", tag, obs, exp, txn);
    end
  endtask

  function automatic logic [NR*DW-1:0] rand_data();
    logic [NR*DW-1:0] d;
    for (int i = 0; i < NR; i++) d[i*DW +: DW] = $urandom;
    return d;
  endfunction

  // One clock of stimulus: called just after a negedge, returns after the next negedge.
  task automatic step(input logic rst, input logic [NR-1:0] v, input logic ordy,
                      input logic [NR*DW-1:0] d);
    logic          can_load;
    bit            found;
    int            win;
    logic [NR-1:0] exp_rdy;
    exp_t          e;
    reset     = rst;
    req_valid = v;
    out_ready = ordy;
    req_data  = d;
    #1;
    can_load = !m_valid || ordy;
    found    = 1'b0;
    win      = 0;
    if (!rst && can_load) begin
      for (int k = 0; k < NR; k++) begin
        int idx;
        idx = (m_ptr + k) % NR;
        if (!found && v[idx]) begin
          found = 1'b1;
          win   = idx;
        end
      end
    end
    exp_rdy = found ? NR'(1 << win) : '0;
    check_eq("req_ready", 64'(req_ready), 64'(exp_rdy));
    if (found) sb_q.push_back({2'(win), d[win*DW +: DW]});

    @(posedge clk);
    #1;
    if (rst) begin
      m_valid = 1'b0; m_data = '0; m_src = '0; m_ptr = 0; m_perf = '0;
      sb_q.delete();
    end else if (found) begin
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL scoreboard_empty: got 0 entries expected 1 (txn %0d)", txn);
      end else begin
        e = sb_q.pop_front();
        m_valid = 1'b1;
        m_data  = e.data;
        m_src   = e.src;
        m_ptr   = (win + 1) % NR;
        m_perf  = m_perf + 32'd1;
      end
    end else if (ordy) begin
      m_valid = 1'b0;
    end
    check_eq("out_valid", 64'(out_valid), 64'(m_valid));
    check_eq("out_data",  64'(out_data),  64'(m_data));
    check_eq("out_src",   64'(out_src),   64'(m_src));
`ifdef ARB_PERF_CNT_EN
    check_eq("perf_grants", 64'(perf_grants), 64'(m_perf));
`endif
    $display("txn %0d rst=%0b valid=%b out_ready=%0b req_ready=%b -> out_valid=%0b out_src=%0d out_data=%08h",
             txn, rst, v, ordy, req_ready, out_valid, out_src, out_data);
    txn++;
    @(negedge clk);
  endtask

  initial begin
    logic [NR*DW-1:0] d;
    reset     = 1'b1;
    req_valid = '0;
    req_data  = '0;
    out_ready = 1'b0;
    @(negedge clk);

    // Reset with every requester asking
    repeat (2) step(1'b1, 4'b1111, 1'b1, rand_data());

    // Single requester 2 with a known payload, then next in line after ptr=3
    d = rand_data();
    d[2*DW +: DW] = 32'h0000_CAFE;
    step(1'b0, 4'b0100, 1'b1, d);
    step(1'b0, 4'b1111, 1'b1, rand_data());
    step(1'b0, 4'b0000, 1'b1, rand_data());

    // Full-throughput rotation
    repeat (5) step(1'b0, 4'b1111, 1'b1, rand_data());

    // Backpressure holds output and blocks grants, then release loads same cycle
    repeat (3) step(1'b0, 4'b1111, 1'b0, rand_data());
    step(1'b0, 4'b1111, 1'b1, rand_data());

    // Wrap and skip
    step(1'b0, 4'b0100, 1'b1, rand_data());
    step(1'b0, 4'b0010, 1'b1, rand_data());
    step(1'b0, 4'b0100, 1'b1, rand_data());
    step(1'b0, 4'b1000, 1'b1, rand_data());
    step(1'b0, 4'b1111, 1'b1, rand_data());

    // Fresh count of five grants, then reset while holding a payload
    step(1'b1, 4'b0000, 1'b0, rand_data());
    repeat (5) step(1'b0, 4'b1111, 1'b1, rand_data());
    step(1'b0, 4'b1111, 1'b0, rand_data());
    step(1'b1, 4'b1111, 1'b0, rand_data());
    step(1'b0, 4'b1111, 1'b1, rand_data());

    // Random traffic with occasional backpressure and idle
    for (int i = 0; i < 40; i++) begin
      step(($urandom_range(0, 19) == 0), NR'($urandom_range(0, 15)),
           ($urandom_range(0, 3) != 0), rand_data());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
